// File: rtl/uop_issue_queue_pkg.sv
// Shared types and constants for the micro-op issue queue: uop bundle, serializing-op mask,
// hazard query record and the hazard rule used by both the head check and the bypass check.
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

package uop_issue_queue_pkg;
  localparam int REG_LEN          = `YSYX_REG_LEN;
  localparam int YSYX_REG_NUM     = 2 ** REG_LEN;
  localparam int IQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic system;
    logic ebreak;
    logic fence_i;
    logic ecall;
    logic mret;
  } uop_ctrl_t;

  // Ops that must wait for every outstanding register write to drain.
  localparam uop_ctrl_t SERIAL_MASK = '{system: 1'b1, ebreak: 1'b1, fence_i: 1'b1,
                                        ecall: 1'b1, mret: 1'b1};

  typedef struct packed {
    logic [31:0]        pc;
    logic [REG_LEN-1:0] rs1;
    logic [REG_LEN-1:0] rs2;
    logic [REG_LEN-1:0] rd;
    logic               wen;
    uop_ctrl_t          ctrl;
  } micro_op_t;

  localparam int UOP_W = $bits(micro_op_t);

  typedef struct packed {
    logic [REG_LEN-1:0] rs1;
    logic [REG_LEN-1:0] rs2;
    logic [REG_LEN-1:0] rd;
    logic               wen;
    logic               serial;
  } hz_query_t;

  localparam int HZQ_W = $bits(hz_query_t);

  function automatic hz_query_t to_query(input micro_op_t u);
    hz_query_t q;
    q.rs1    = u.rs1;
    q.rs2    = u.rs2;
    q.rd     = u.rd;
    q.wen    = u.wen;
    q.serial = |(u.ctrl & SERIAL_MASK);
    return q;
  endfunction

  function automatic logic uop_hazard(input hz_query_t q, input logic [YSYX_REG_NUM-1:0] busy_eff);
    return busy_eff[q.rs1] | busy_eff[q.rs2] | (q.wen & busy_eff[q.rd]) |
           (q.serial & (|busy_eff));
  endfunction
endpackage

// File: rtl/uop_issue_queue_scoreboard.sv
// Per-register pending-write scoreboard; reports hazards against next-state busy bits so a
// writeback in the same cycle wakes a dependent uop. Bypass query port under YSYX_IQ_BYPASS_EN.
module uop_scoreboard
  import uop_issue_queue_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    set_valid,
  input  logic [REG_LEN-1:0]      set_rd,
  input  logic                    wb_valid,
  input  logic [REG_LEN-1:0]      wb_rd,
  input  logic [HZQ_W-1:0]        head_q_in,
  output logic                    head_hazard,
`ifdef YSYX_IQ_BYPASS_EN
  input  logic [HZQ_W-1:0]        byp_q_in,
  output logic                    byp_hazard,
`endif
  output logic [YSYX_REG_NUM-1:0] busy_vec
);

  logic [YSYX_REG_NUM-1:0] busy_q, busy_d, busy_eff;

  always_comb begin
    busy_eff = busy_q;
    if (wb_valid) busy_eff[wb_rd] = 1'b0;
    busy_eff[0] = 1'b0;

    head_hazard = uop_hazard(hz_query_t'(head_q_in), busy_eff);
`ifdef YSYX_IQ_BYPASS_EN
    byp_hazard  = uop_hazard(hz_query_t'(byp_q_in), busy_eff);
`endif

    // Set is applied after the clear so an issue and a writeback to the same rd keep it busy.
    busy_d = busy_eff;
    if (set_valid && (set_rd != '0)) busy_d[set_rd] = 1'b1;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/uop_issue_queue.sv
// In-order micro-op issue queue between IDU and EXU with scoreboard-gated issue.
// Optional same-cycle bypass of an empty queue is enabled by defining YSYX_IQ_BYPASS_EN.
module uop_issue_queue
  import uop_issue_queue_pkg::*;
#(
  parameter int DEPTH   = IQ_DEPTH_DEFAULT,
  parameter int REG_NUM = YSYX_REG_NUM
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [UOP_W-1:0]           in_uop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [UOP_W-1:0]           out_uop,
  input  logic                       wb_valid,
  input  logic [REG_LEN-1:0]         wb_rd,
  output logic [$clog2(DEPTH):0]     count,
  output logic [REG_NUM-1:0]         busy_vec
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  micro_op_t     mem_q [DEPTH];

  micro_op_t head_uop, in_uop_s, issued;
  logic      head_hazard, head_ok, byp, enq, deq;

  assign head_uop = mem_q[head_q];
  assign in_uop_s = micro_op_t'(in_uop);

`ifdef YSYX_IQ_BYPASS_EN
  logic byp_hazard;
`endif

  always_comb begin
    in_ready = (count_q != CW'(DEPTH)) && !flush;
    head_ok  = (count_q != '0) && !head_hazard && !flush;
    byp      = 1'b0;
`ifdef YSYX_IQ_BYPASS_EN
    byp      = (count_q == '0) && in_valid && out_ready && !flush && !byp_hazard;
`endif
    out_valid = head_ok || byp;
    issued    = head_ok ? head_uop : (byp ? in_uop_s : '0);
    deq       = out_valid && out_ready;
    enq       = in_valid && in_ready && !byp;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (head_ok && out_ready) head_d = head_q + 1'b1;
    if (enq)                  tail_d = tail_q + 1'b1;
    if (enq && !(head_ok && out_ready))      count_d = count_q + 1'b1;
    else if (!enq && (head_ok && out_ready)) count_d = count_q - 1'b1;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (enq) mem_q[tail_q] <= in_uop_s;
  end

  uop_scoreboard u_sb (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .set_valid   (deq && issued.wen),
    .set_rd      (issued.rd),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .head_q_in   (to_query(head_uop)),
    .head_hazard (head_hazard),
`ifdef YSYX_IQ_BYPASS_EN
    .byp_q_in    (to_query(in_uop_s)),
    .byp_hazard  (byp_hazard),
`endif
    .busy_vec    (busy_vec)
  );

  assign out_uop = issued;
  assign count   = count_q;

endmodule

// File: doc/uop_issue_queue.md
Name: uop_issue_queue

Overview:
- Consumer end of the IDU micro-op pipe. Accepts decoded micro_op_t bundles from the IDU over a valid/ready handshake and buffers them in an in-order FIFO.
- Issues the head entry to the EXU only when a per-register scoreboard shows no RAW or WAW hazard.
- Scoreboard busy bits are cleared by writeback. Sits between the IDU and the EXU.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
REG_NUM, 2**`YSYX_REG_LEN, architectural register count tracked by the scoreboard.

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous reset, active-low (asserted at 0).
flush  input  1  pipeline flush (redirect/trap).
in_valid  input  1  IDU has a micro-op.
in_ready  output  1  queue can accept.
in_uop  input  $bits(micro_op_t)  decoded micro-op.
out_valid  output  1  head is issuable.
out_ready  input  1  EXU accepts.
out_uop  output  $bits(micro_op_t)  head micro-op.
wb_valid  input  1  writeback retiring a register write.
wb_rd  input  `YSYX_REG_LEN  writeback destination.
count  output  $clog2(DEPTH)+1  occupied entries.
busy_vec  output  REG_NUM  scoreboard state, bit i = register i has a pending write.

Behaviour:

Reset (reset=0, asynchronous):
- head, tail and count go to 0; busy_vec goes to 0.
- out_valid=0, out_uop=0, in_ready=1.
- Storage array is not reset.
- Reset mid-operation discards all entries and pending scoreboard bits.

Enqueue:
- in_ready = (count != DEPTH) && !flush.
- in_ready has no combinational dependence on out_ready; a full queue refuses input even if a dequeue happens the same cycle.
- Accept when in_valid && in_ready: write at tail; tail increments mod DEPTH.

Hazard check on the head entry, using next-state busy:
- busy_eff[r] = busy[r] && !(wb_valid && wb_rd==r). Same-cycle wake-up is allowed.
- hazard = busy_eff[rs1] || busy_eff[rs2] || (wen_head && busy_eff[rd]).
- x0 is never busy.
- Serializing ops (system | ebreak | fence_i | ecall | mret) additionally require busy_eff == 0 for all registers.

Issue:
- out_valid = (count != 0) && !hazard && !flush.
- out_uop = head entry when out_valid, else 0.
- Dequeue when out_valid && out_ready: head increments mod DEPTH.

Count:
- Increments on enqueue only, decrements on dequeue only, unchanged on both.
- Never exceeds DEPTH and never underflows.

Scoreboard:
- On dequeue with wen && rd != 0: set busy[rd].
- On wb_valid with wb_rd != 0: clear busy[wb_rd].
- If set and clear hit the same register in the same cycle, set wins.

Flush:
- Next edge: head=tail=count=0 and busy_vec=0.
- In the flush cycle: enqueue blocked, out_valid forced 0, wb ignored.

Latency:
- Minimum 1 cycle from enqueue to out_valid.

Optional Feature:
- Macro: YSYX_IQ_BYPASS_EN.
- Defined: when count==0, in_valid=1, in_uop is hazard-free (same rules) and out_ready=1, the uop is presented on out_uop/out_valid combinationally and issued in the same cycle without being written. Scoreboard is set as for a normal dequeue. Latency 0.
- Undefined: no bypass; minimum 1-cycle latency.

Decomposition:
- micro_op_t and `YSYX_REG_LEN stay in the shared ysyx include.
- Add a shared package constant for the serializing-op mask fields and an issue-queue depth default.
- One natural sub-module: uop_scoreboard (busy bits, set/clear/precedence, busy_eff and hazard outputs). The FIFO stays inline.

Test Plan:
- Reset held low mid-stream with 3 entries queued -> count=0, busy_vec=0, out_valid=0, in_ready=1 immediately (asynchronous).
- Fill 4 independent uops with out_ready=0 -> count=4, in_ready=0. Assert out_ready=1 and in_valid=1 together -> one dequeue, no enqueue, count=3.
- Issue uop (rd=5, wen=1); next head uses rs1=5 -> out_valid=0 until wb_valid=1, wb_rd=5. In that same cycle out_valid=1 (wake-up).
- Dequeue sets rd=7 while wb_valid clears wb_rd=7 in the same cycle -> busy_vec[7]=1 afterwards.
- Head is fence_i with busy_vec={x3} and rs fields 0 -> stalls until x3 writes back, then issues.
- flush=1 with 2 entries and busy x9 -> next cycle count=0, busy_vec=0, in_valid ignored during the flush cycle. With YSYX_IQ_BYPASS_EN: empty queue plus a hazard-free uop -> out_valid the same cycle and count stays 0.
